// File: rtl/fwd_scoreboard.sv
// Operand forwarding and hazard unit with a multicycle-op busy scoreboard.
// Bypasses producer taps and mc writeback; stalls on load-use, busy and WAW.
module fwd_scoreboard #(
  parameter int NUM_FWD = 3,
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int CNT_W   = 32,
  localparam int RW     = $clog2(NREG)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s3_valid,
  input  logic                    s3_use_rs1,
  input  logic                    s3_use_rs2,
  input  logic                    s3_write_rd,
  input  logic                    s3_multicycle,
  input  logic [RW-1:0]           s3_rs1,
  input  logic [RW-1:0]           s3_rs2,
  input  logic [RW-1:0]           s3_rd,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_write_rd,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  input  logic [NUM_FWD*RW-1:0]   fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_value,
  input  logic                    st_valid,
  input  logic [RW-1:0]           st_rs2,
  input  logic                    mc_wb_valid,
  input  logic [RW-1:0]           mc_wb_rd,
  input  logic [XLEN-1:0]         mc_wb_value,
  input  logic                    mc_kill,
  output logic                    stall,
  output logic [1:0]              s3_bypass,
  output logic [XLEN-1:0]         s3_bypass_rs1,
  output logic [XLEN-1:0]         s3_bypass_rs2,
  output logic                    st_bypass,
  output logic [XLEN-1:0]         st_bypass_rs2,
  output logic [NREG-1:0]         busy,
  output logic [CNT_W-1:0]        load_stall_cnt,
  output logic [CNT_W-1:0]        mc_stall_cnt
);

  // Source slots: 0 = s3 rs1, 1 = s3 rs2, 2 = store data
  logic [2:0][RW-1:0]   src;
  logic [2:0]           act;
  logic [2:0]           hit;
  logic [2:0]           haz;
  logic [2:0]           byp;
  logic [2:0]           mc_cov;
  logic [2:0][XLEN-1:0] val;
  logic [NREG-1:0]      busy_q;
  logic [NREG-1:0]      busy_d;
  logic                 sb_haz;
  logic                 waw;
  logic                 load_haz;
  logic                 issue;

  assign src = {st_rs2, s3_rs2, s3_rs1};
  assign act = {st_valid,
                s3_valid && s3_use_rs2,
                s3_valid && s3_use_rs1};

  always_comb begin
    hit    = '0;
    haz    = '0;
    byp    = '0;
    mc_cov = '0;
    val    = '0;
    for (int k = 0; k < 3; k++) begin
      mc_cov[k] = mc_wb_valid && (mc_wb_rd == src[k])
                  && (src[k] != '0);
      // Store data is read at tap 0 itself, so it never sources it
      for (int i = 0; i < NUM_FWD; i++) begin
        if (act[k] && !hit[k] && !(k == 2 && i == 0)
            && fwd_valid[i] && fwd_write_rd[i]
            && (src[k] != '0)
            && (fwd_rd[i*RW +: RW] == src[k])) begin
          hit[k] = 1'b1;
          if (fwd_ready[i]) begin
            byp[k] = 1'b1;
            val[k] = fwd_value[i*XLEN +: XLEN];
          end else begin
            haz[k] = 1'b1;
          end
        end
      end
      if (act[k] && !hit[k] && mc_cov[k]) begin
        byp[k] = 1'b1;
        val[k] = mc_wb_value;
      end
    end
  end

  assign sb_haz = (act[0] && busy_q[src[0]] && !hit[0] && !mc_cov[0])
               || (act[1] && busy_q[src[1]] && !hit[1] && !mc_cov[1]);

  assign waw = s3_valid && s3_write_rd && (s3_rd != '0)
            && busy_q[s3_rd]
            && !(mc_wb_valid && (mc_wb_rd == s3_rd));

  assign load_haz = |haz;
  assign stall    = !reset && (load_haz || sb_haz || waw);
  assign issue    = s3_valid && s3_multicycle && s3_write_rd
                 && (s3_rd != '0) && !stall && !mc_kill;

  always_comb begin
    busy_d = busy_q;
    if (mc_wb_valid) busy_d[mc_wb_rd] = 1'b0;
    if (issue)       busy_d[s3_rd]    = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset || mc_kill) busy_q <= '0;
    else                  busy_q <= busy_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      load_stall_cnt <= '0;
      mc_stall_cnt   <= '0;
    end else begin
      if (stall && load_haz && load_stall_cnt != '1)
        load_stall_cnt <= load_stall_cnt + CNT_W'(1);
      if (stall && !load_haz && mc_stall_cnt != '1)
        mc_stall_cnt <= mc_stall_cnt + CNT_W'(1);
    end
  end

  assign s3_bypass     = byp[1:0];
  assign s3_bypass_rs1 = val[0];
  assign s3_bypass_rs2 = val[1];
  assign st_bypass     = byp[2];
  assign st_bypass_rs2 = val[2];
  assign busy          = busy_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: driver queues expectations,
// a negedge monitor pops and compares them.
module tb_fwd_scoreboard;

  logic        clock = 0;
  logic        reset;
  logic        s3_valid, s3_use_rs1, s3_use_rs2;
  logic        s3_write_rd, s3_multicycle;
  logic [4:0]  s3_rs1, s3_rs2, s3_rd;
  logic [2:0]  fv, fw, fr;
  logic [14:0] frd;
  logic [95:0] fval;
  logic        st_valid;
  logic [4:0]  st_rs2;
  logic        mc_wb_valid;
  logic [4:0]  mc_wb_rd;
  logic [31:0] mc_wb_value;
  logic        mc_kill;
  logic        stall;
  logic [1:0]  s3_bypass;
  logic [31:0] s3_bypass_rs1, s3_bypass_rs2;
  logic        st_bypass;
  logic [31:0] st_bypass_rs2;
  logic [31:0] busy;
  logic [31:0] load_stall_cnt, mc_stall_cnt;

  fwd_scoreboard dut (
    .clock(clock), .reset(reset),
    .s3_valid(s3_valid), .s3_use_rs1(s3_use_rs1),
    .s3_use_rs2(s3_use_rs2), .s3_write_rd(s3_write_rd),
    .s3_multicycle(s3_multicycle),
    .s3_rs1(s3_rs1), .s3_rs2(s3_rs2), .s3_rd(s3_rd),
    .fwd_valid(fv), .fwd_write_rd(fw), .fwd_ready(fr),
    .fwd_rd(frd), .fwd_value(fval),
    .st_valid(st_valid), .st_rs2(st_rs2),
    .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd),
    .mc_wb_value(mc_wb_value), .mc_kill(mc_kill),
    .stall(stall), .s3_bypass(s3_bypass),
    .s3_bypass_rs1(s3_bypass_rs1), .s3_bypass_rs2(s3_bypass_rs2),
    .st_bypass(st_bypass), .st_bypass_rs2(st_bypass_rs2),
    .busy(busy), .load_stall_cnt(load_stall_cnt),
    .mc_stall_cnt(mc_stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        st;
    logic [1:0]  b;
    logic [31:0] v1, v2;
    logic        sb;
    logic [31:0] sv, busy, lc, mc;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    pass_n = 0;
  int    tot_n  = 0;
  logic [31:0] eb, elc, emc;

  task automatic chk(string nm, string f,
                     logic [31:0] act, logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s.%s got=%h want=%h", nm, f, act, exp);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t  e;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      chk(n, "stall", 32'(stall), 32'(e.st));
      chk(n, "byp", 32'(s3_bypass), 32'(e.b));
      chk(n, "rs1", s3_bypass_rs1, e.v1);
      chk(n, "rs2", s3_bypass_rs2, e.v2);
      chk(n, "stb", 32'(st_bypass), 32'(e.sb));
      chk(n, "stv", st_bypass_rs2, e.sv);
      chk(n, "busy", busy, e.busy);
      chk(n, "lcnt", load_stall_cnt, e.lc);
      chk(n, "mcnt", mc_stall_cnt, e.mc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    s3_valid = 0; s3_use_rs1 = 0; s3_use_rs2 = 0;
    s3_write_rd = 0; s3_multicycle = 0;
    s3_rs1 = 0; s3_rs2 = 0; s3_rd = 0;
    fv = 0; fw = 0; fr = 0; frd = 0; fval = 0;
    st_valid = 0; st_rs2 = 0;
    mc_wb_valid = 0; mc_wb_rd = 0; mc_wb_value = 0;
    mc_kill = 0;
  endtask

  task automatic tap(int i, logic [4:0] rd,
                     logic [31:0] v, logic rdy);
    fv[i] = 1; fw[i] = 1; fr[i] = rdy;
    frd[i*5 +: 5]   = rd;
    fval[i*32 +: 32] = v;
  endtask

  task automatic rd1(logic [4:0] r);
    s3_valid = 1; s3_use_rs1 = 1; s3_rs1 = r;
  endtask

  task automatic rd2(logic [4:0] r);
    s3_valid = 1; s3_use_rs2 = 1; s3_rs2 = r;
  endtask

  task automatic mc_issue(logic [4:0] r);
    s3_valid = 1; s3_multicycle = 1; s3_write_rd = 1; s3_rd = r;
  endtask

  task automatic mcwb(logic [4:0] r, logic [31:0] v);
    mc_wb_valid = 1; mc_wb_rd = r; mc_wb_value = v;
  endtask

  task automatic expect_(string nm, logic st, logic [1:0] b,
                         logic [31:0] v1, logic [31:0] v2,
                         logic sb, logic [31:0] sv);
    exp_t e;
    e.st = st; e.b = b; e.v1 = v1; e.v2 = v2;
    e.sb = sb; e.sv = sv;
    e.busy = eb; e.lc = elc; e.mc = emc;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    eb = 0; elc = 0; emc = 0;
    reset = 1;
    tick(); reset = 1;
    expect_("rst_idle", 0, 0, 0, 0, 0, 0);
    tick(); reset = 1;
    tap(0, 7, 0, 0); rd2(7);
    expect_("rst_nostall", 0, 0, 0, 0, 0, 0);

    tick(); reset = 0;
    tap(0, 5, 32'h11, 1); rd1(5);
    expect_("tap0_rs1", 0, 2'b01, 32'h11, 0, 0, 0);
    tick();
    tap(0, 5, 32'h11, 1); tap(2, 5, 32'h22, 1); rd1(5);
    expect_("youngest", 0, 2'b01, 32'h11, 0, 0, 0);

    tick();
    tap(0, 7, 0, 0); rd2(7);
    expect_("load_use", 1, 0, 0, 0, 0, 0);
    tick(); elc = 1;
    tap(0, 7, 0, 0); tap(1, 7, 32'h99, 1); rd2(7);
    expect_("load_nomask", 1, 0, 0, 0, 0, 0);
    tick(); elc = 2;
    tap(1, 7, 32'h5, 1); rd2(7);
    expect_("load_ready", 0, 2'b10, 0, 32'h5, 0, 0);

    tick();
    mc_issue(9);
    expect_("mul_issue", 0, 0, 0, 0, 0, 0);
    eb = 32'h200;
    for (int c = 1; c <= 9; c++) begin
      tick(); emc = 32'(c - 1);
      rd1(9);
      expect_("busy_stall", 1, 0, 0, 0, 0, 0);
    end
    tick(); emc = 9;
    rd1(9); mcwb(9, 32'hABCD);
    expect_("mc_wb_fwd", 0, 2'b01, 32'hABCD, 0, 0, 0);
    tick(); eb = 0;
    expect_("busy_drop", 0, 0, 0, 0, 0, 0);

    tick();
    mc_issue(4);
    expect_("div_issue", 0, 0, 0, 0, 0, 0);
    tick(); eb = 32'h10;
    mc_issue(4); mcwb(4, 32'h44);
    expect_("wb_and_issue", 0, 0, 0, 0, 0, 0);
    tick();
    s3_valid = 1; s3_write_rd = 1; s3_rd = 4;
    expect_("waw_stall", 1, 0, 0, 0, 0, 0);
    tick(); emc = 10;
    mc_issue(3);
    expect_("issue_x3", 0, 0, 0, 0, 0, 0);
    tick(); eb = 32'h18;
    mc_issue(6);
    expect_("issue_x6", 0, 0, 0, 0, 0, 0);
    tick(); eb = 32'h58;
    mc_kill = 1; mc_issue(10);
    expect_("kill", 0, 0, 0, 0, 0, 0);
    tick(); eb = 0;
    mcwb(6, 32'h66); rd2(6);
    expect_("stale_wb", 0, 2'b10, 0, 32'h66, 0, 0);
    tick();
    expect_("after_stale", 0, 0, 0, 0, 0, 0);

    tick();
    st_valid = 1; st_rs2 = 8; tap(1, 8, 32'h77, 1);
    expect_("st_tap1", 0, 0, 0, 0, 1, 32'h77);
    tick();
    st_valid = 1; st_rs2 = 8; tap(0, 8, 32'h55, 1);
    expect_("st_tap0_ign", 0, 0, 0, 0, 0, 0);
    tick();
    st_valid = 1; st_rs2 = 8;
    tap(0, 8, 32'h55, 1); tap(1, 8, 32'h77, 1);
    expect_("st_skip0", 0, 0, 0, 0, 1, 32'h77);
    tick();
    st_valid = 1; st_rs2 = 8; tap(1, 8, 0, 0);
    expect_("st_load", 1, 0, 0, 0, 0, 0);
    tick(); elc = 3;
    tap(0, 0, 32'hDEAD, 1); tap(1, 0, 0, 0);
    rd1(0); rd2(0); st_valid = 1; st_rs2 = 0;
    mcwb(0, 32'hBEEF); mc_issue(0);
    expect_("x0", 0, 0, 0, 0, 0, 0);
    tick();
    expect_("x0_nobusy", 0, 0, 0, 0, 0, 0);

    tick();
    tick();
    tot_n++;
    if (q.size() == 0) pass_n++;
    else $display("FAIL drain got=%0d want=0", q.size());
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
